// File: rtl/iq_exec_unit.sv
// iq_exec_unit: one ALU issue slot at the consumer end of the issue bus.
//
// The unit takes one command per handshake and steps through these states:
//   IDLE -> RD1 (operand 1) -> RD2 (operand 2) -> EXEC -> WB -> IDLE
// It resolves each operand through the shared operand read bus, from either
// the regfile or a ROB entry. It runs one integer ALU op and presents the
// result on the writeback bus, tagged with the command's IQ position.
//
// Ports:
//   clk, nrst        clock (rising edge); asynchronous active-low reset
//   flush            synchronous squash of the in-flight command
//   cmd_*            issue bus: valid/ready handshake plus command fields
//   rd_req/rd_is_dep/rd_addr   operand read request (held until serviced)
//   rd_ack/rd_data_valid/rd_data  read response; ack without valid = retry
//   wb_valid/wb_ready          writeback handshake
//   wb_iq_pos/wb_reg_we/wb_rd_addr/wb_data  writeback payload
//   busy             unit is not idle
//
// All outputs except busy are registered. busy decodes the state register.
module iq_exec_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned IQ_POS_W   = 3,
  parameter int unsigned IMM_W      = 16,
  parameter int unsigned OP_W       = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  flush,
  // issue bus
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [OP_W-1:0]       cmd_op,
  input  logic [IQ_POS_W-1:0]   cmd_iq_pos,
  input  logic                  cmd_a1_use_reg,
  input  logic                  cmd_a1_use_dep,
  input  logic [REG_ADDR_W-1:0] cmd_rs1_addr,
  input  logic [IQ_POS_W-1:0]   cmd_dep1,
  input  logic                  cmd_a2_use_reg,
  input  logic                  cmd_a2_use_dep,
  input  logic                  cmd_a2_use_imm,
  input  logic [REG_ADDR_W-1:0] cmd_rs2_addr,
  input  logic [IQ_POS_W-1:0]   cmd_dep2,
  input  logic [IMM_W-1:0]      cmd_imm,
  input  logic                  cmd_reg_we,
  input  logic [REG_ADDR_W-1:0] cmd_rd_addr,
  // operand read bus
  output logic                  rd_req,
  output logic                  rd_is_dep,
  output logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  rd_ack,
  input  logic                  rd_data_valid,
  input  logic [DATA_W-1:0]     rd_data,
  // writeback bus
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [IQ_POS_W-1:0]   wb_iq_pos,
  output logic                  wb_reg_we,
  output logic [REG_ADDR_W-1:0] wb_rd_addr,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  busy
);

  typedef enum logic [2:0] {
    StIdle,
    StRd1,
    StRd2,
    StExec,
    StWb
  } state_e;

  localparam logic [OP_W-1:0] OpAdd   = OP_W'(0);
  localparam logic [OP_W-1:0] OpSub   = OP_W'(1);
  localparam logic [OP_W-1:0] OpAnd   = OP_W'(2);
  localparam logic [OP_W-1:0] OpOr    = OP_W'(3);
  localparam logic [OP_W-1:0] OpXor   = OP_W'(4);
  localparam logic [OP_W-1:0] OpSll   = OP_W'(5);
  localparam logic [OP_W-1:0] OpSrl   = OP_W'(6);
  localparam logic [OP_W-1:0] OpSra   = OP_W'(7);
  localparam logic [OP_W-1:0] OpSlt   = OP_W'(8);
  localparam logic [OP_W-1:0] OpSltu  = OP_W'(9);
  localparam logic [OP_W-1:0] OpSeq   = OP_W'(10);
  localparam logic [OP_W-1:0] OpSne   = OP_W'(11);
  localparam logic [OP_W-1:0] OpPassb = OP_W'(12);

  state_e state;

  // Latched command fields still needed after acceptance.
  logic [OP_W-1:0]       op_q;
  logic [IQ_POS_W-1:0]   iq_pos_q;
  logic                  a2_use_reg_q;
  logic                  a2_use_dep_q;
  logic                  a2_use_imm_q;
  logic [REG_ADDR_W-1:0] rs2_q;
  logic [IQ_POS_W-1:0]   dep2_q;
  logic [IMM_W-1:0]      imm_q;
  logic                  reg_we_q;
  logic [REG_ADDR_W-1:0] rd_q;

  logic [DATA_W-1:0]     op1_q;
  logic [DATA_W-1:0]     op2_q;

  // Operand read decode. Operand 1 is decoded from the incoming command, so
  // its request can be registered on the accepting edge. Operand 2 is
  // decoded from the latched fields.
  logic                  op1_req;
  logic [REG_ADDR_W-1:0] op1_addr;
  logic                  op2_req;
  logic [REG_ADDR_W-1:0] op2_addr;
  logic [DATA_W-1:0]     op2_static;
  logic [DATA_W-1:0]     alu_res;
  logic [4:0]            sh;

  always_comb begin
    op1_req  = cmd_a1_use_dep | (cmd_a1_use_reg & (cmd_rs1_addr != '0));
    op1_addr = '0;
    if (cmd_a1_use_dep) begin
      op1_addr = REG_ADDR_W'(cmd_dep1);
    end else if (op1_req) begin
      op1_addr = cmd_rs1_addr;
    end

    op2_req    = a2_use_dep_q | (a2_use_reg_q & (rs2_q != '0));
    op2_addr   = '0;
    op2_static = '0;
    if (a2_use_dep_q) begin
      op2_addr = REG_ADDR_W'(dep2_q);
    end else if (a2_use_reg_q) begin
      // A register source outranks the immediate; a read of r0 yields zero.
      op2_addr = op2_req ? rs2_q : '0;
    end else if (a2_use_imm_q) begin
      op2_static = DATA_W'($signed(imm_q));
    end
  end

  always_comb begin
    sh      = op2_q[4:0];
    alu_res = '0;
    case (op_q)
      OpAdd:   alu_res = op1_q + op2_q;
      OpSub:   alu_res = op1_q - op2_q;
      OpAnd:   alu_res = op1_q & op2_q;
      OpOr:    alu_res = op1_q | op2_q;
      OpXor:   alu_res = op1_q ^ op2_q;
      OpSll:   alu_res = op1_q << sh;
      OpSrl:   alu_res = op1_q >> sh;
      OpSra:   alu_res = DATA_W'($signed(op1_q) >>> sh);
      OpSlt:   alu_res = ($signed(op1_q) < $signed(op2_q)) ? DATA_W'(1) : '0;
      OpSltu:  alu_res = (op1_q < op2_q) ? DATA_W'(1) : '0;
      OpSeq:   alu_res = (op1_q == op2_q) ? DATA_W'(1) : '0;
      OpSne:   alu_res = (op1_q != op2_q) ? DATA_W'(1) : '0;
      OpPassb: alu_res = op2_q;
      default: alu_res = '0;
    endcase
  end

  assign busy = (state != StIdle);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= StIdle;
      cmd_ready    <= 1'b0;
      rd_req       <= 1'b0;
      rd_is_dep    <= 1'b0;
      rd_addr      <= '0;
      wb_valid     <= 1'b0;
      wb_iq_pos    <= '0;
      wb_reg_we    <= 1'b0;
      wb_rd_addr   <= '0;
      wb_data      <= '0;
      op_q         <= '0;
      iq_pos_q     <= '0;
      a2_use_reg_q <= 1'b0;
      a2_use_dep_q <= 1'b0;
      a2_use_imm_q <= 1'b0;
      rs2_q        <= '0;
      dep2_q       <= '0;
      imm_q        <= '0;
      reg_we_q     <= 1'b0;
      rd_q         <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
    end else if (flush && (state != StIdle)) begin
      // Squash: the in-flight command and any pending result are dropped.
      state     <= StIdle;
      cmd_ready <= 1'b1;
      rd_req    <= 1'b0;
      rd_is_dep <= 1'b0;
      rd_addr   <= '0;
      wb_valid  <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready && !flush) begin
            cmd_ready    <= 1'b0;
            op_q         <= cmd_op;
            iq_pos_q     <= cmd_iq_pos;
            a2_use_reg_q <= cmd_a2_use_reg;
            a2_use_dep_q <= cmd_a2_use_dep;
            a2_use_imm_q <= cmd_a2_use_imm;
            rs2_q        <= cmd_rs2_addr;
            dep2_q       <= cmd_dep2;
            imm_q        <= cmd_imm;
            reg_we_q     <= cmd_reg_we;
            rd_q         <= cmd_rd_addr;
            rd_req       <= op1_req;
            rd_is_dep    <= cmd_a1_use_dep;
            rd_addr      <= op1_addr;
            op1_q        <= '0;
            state        <= StRd1;
          end
        end
        StRd1: begin
          // Without a request this state lasts exactly one cycle.
          if (!rd_req || (rd_ack && rd_data_valid)) begin
            if (rd_req) begin
              op1_q <= rd_data;
            end
            rd_req    <= op2_req;
            rd_is_dep <= a2_use_dep_q;
            rd_addr   <= op2_addr;
            op2_q     <= op2_static;
            state     <= StRd2;
          end
        end
        StRd2: begin
          if (!rd_req || (rd_ack && rd_data_valid)) begin
            if (rd_req) begin
              op2_q <= rd_data;
            end
            rd_req    <= 1'b0;
            rd_is_dep <= 1'b0;
            rd_addr   <= '0;
            state     <= StExec;
          end
        end
        StExec: begin
          wb_data    <= alu_res;
          wb_iq_pos  <= iq_pos_q;
          wb_reg_we  <= reg_we_q;
          wb_rd_addr <= rd_q;
          wb_valid   <= 1'b1;
          state      <= StWb;
        end
        StWb: begin
          if (wb_ready) begin
            wb_valid  <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= StIdle;
          end
        end
        default: begin
          state     <= StIdle;
          cmd_ready <= 1'b1;
          rd_req    <= 1'b0;
          wb_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iq_exec_unit.sv
// Directed, table-driven bench for iq_exec_unit. A small regfile/ROB
// responder answers operand reads; every expected value is hand-computed.
module tb_iq_exec_unit;

  logic        clk = 1'b0;
  logic        nrst;
  logic        flush;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [2:0]  cmd_iq_pos;
  logic        cmd_a1_use_reg, cmd_a1_use_dep;
  logic [4:0]  cmd_rs1_addr;
  logic [2:0]  cmd_dep1;
  logic        cmd_a2_use_reg, cmd_a2_use_dep, cmd_a2_use_imm;
  logic [4:0]  cmd_rs2_addr;
  logic [2:0]  cmd_dep2;
  logic [15:0] cmd_imm;
  logic        cmd_reg_we;
  logic [4:0]  cmd_rd_addr;
  logic        rd_req, rd_is_dep;
  logic [4:0]  rd_addr;
  logic        rd_ack, rd_data_valid;
  logic [31:0] rd_data;
  logic        wb_valid, wb_ready;
  logic [2:0]  wb_iq_pos;
  logic        wb_reg_we;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic        busy;

  iq_exec_unit dut (
    .clk            (clk),
    .nrst           (nrst),
    .flush          (flush),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_iq_pos     (cmd_iq_pos),
    .cmd_a1_use_reg (cmd_a1_use_reg),
    .cmd_a1_use_dep (cmd_a1_use_dep),
    .cmd_rs1_addr   (cmd_rs1_addr),
    .cmd_dep1       (cmd_dep1),
    .cmd_a2_use_reg (cmd_a2_use_reg),
    .cmd_a2_use_dep (cmd_a2_use_dep),
    .cmd_a2_use_imm (cmd_a2_use_imm),
    .cmd_rs2_addr   (cmd_rs2_addr),
    .cmd_dep2       (cmd_dep2),
    .cmd_imm        (cmd_imm),
    .cmd_reg_we     (cmd_reg_we),
    .cmd_rd_addr    (cmd_rd_addr),
    .rd_req         (rd_req),
    .rd_is_dep      (rd_is_dep),
    .rd_addr        (rd_addr),
    .rd_ack         (rd_ack),
    .rd_data_valid  (rd_data_valid),
    .rd_data        (rd_data),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_iq_pos      (wb_iq_pos),
    .wb_reg_we      (wb_reg_we),
    .wb_rd_addr     (wb_rd_addr),
    .wb_data        (wb_data),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic        a1r, a1d;
    logic [4:0]  rs1;
    logic [2:0]  dep1;
    logic        a2r, a2d, a2i;
    logic [4:0]  rs2;
    logic [2:0]  dep2;
    logic [15:0] imm;
    logic        we;
    logic [4:0]  rd;
    logic [2:0]  iq;
    int          nack;      // retries given to the first read
    int          exp_reqs;  // cycles with rd_req high, retries included
    logic [31:0] exp;
  } vec_t;

  localparam int NVec = 14;
  vec_t tbl [NVec];

  logic [31:0] rf  [32];
  logic [31:0] rob [8];

  int checks = 0;
  int failures = 0;
  int nack_left = 0;
  int req_cycles = 0;
  logic prev_nack = 1'b0;
  logic [4:0] saved_addr;
  logic saved_dep;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge, then answer any pending read.
  task automatic cycle();
    @(negedge clk);
    if (rd_req && nrst) begin
      req_cycles++;
      if (prev_nack) begin
        chk("rd_hold_addr", 32'(rd_addr), 32'(saved_addr));
        chk("rd_hold_dep", 32'(rd_is_dep), 32'(saved_dep));
      end
      rd_ack = 1'b1;
      if (nack_left > 0) begin
        nack_left--;
        rd_data_valid = 1'b0;
        rd_data = 32'hDEADBEEF;
        prev_nack = 1'b1;
        saved_addr = rd_addr;
        saved_dep = rd_is_dep;
      end else begin
        rd_data_valid = 1'b1;
        rd_data = rd_is_dep ? rob[rd_addr[2:0]] : rf[rd_addr];
        prev_nack = 1'b0;
      end
    end else begin
      rd_ack = 1'b0;
      rd_data_valid = 1'b0;
      rd_data = '0;
      prev_nack = 1'b0;
    end
  endtask

  task automatic drive_cmd(input vec_t v);
    cmd_op = v.op;
    cmd_a1_use_reg = v.a1r;
    cmd_a1_use_dep = v.a1d;
    cmd_rs1_addr = v.rs1;
    cmd_dep1 = v.dep1;
    cmd_a2_use_reg = v.a2r;
    cmd_a2_use_dep = v.a2d;
    cmd_a2_use_imm = v.a2i;
    cmd_rs2_addr = v.rs2;
    cmd_dep2 = v.dep2;
    cmd_imm = v.imm;
    cmd_reg_we = v.we;
    cmd_rd_addr = v.rd;
    cmd_iq_pos = v.iq;
  endtask

  // Issue a command and wait for its writeback; returns with wb_valid seen.
  task automatic issue_to_wb(input vec_t v, output int lat);
    drive_cmd(v);
    cmd_valid = 1'b1;
    nack_left = v.nack;
    req_cycles = 0;
    cycle();
    cmd_valid = 1'b0;
    lat = 1;
    while (!wb_valid && lat < 30) begin
      cycle();
      lat++;
    end
  endtask

  task automatic run_vec(input int i, input int stall);
    vec_t v;
    int lat;
    v = tbl[i];
    chk($sformatf("v%0d_ready_before", i), 32'(cmd_ready), 32'd1);
    issue_to_wb(v, lat);
    chk($sformatf("v%0d_latency", i), 32'(lat), 32'(4 + v.nack));
    chk($sformatf("v%0d_req_cycles", i), 32'(req_cycles), 32'(v.exp_reqs));
    chk($sformatf("v%0d_data", i), wb_data, v.exp);
    chk($sformatf("v%0d_rd_addr", i), 32'(wb_rd_addr), 32'(v.rd));
    chk($sformatf("v%0d_iq_pos", i), 32'(wb_iq_pos), 32'(v.iq));
    chk($sformatf("v%0d_reg_we", i), 32'(wb_reg_we), 32'(v.we));
    for (int s = 0; s < stall; s++) begin
      cycle();
      chk($sformatf("v%0d_stall_valid", i), 32'(wb_valid), 32'd1);
      chk($sformatf("v%0d_stall_data", i), wb_data, v.exp);
      chk($sformatf("v%0d_stall_rd", i), 32'(wb_rd_addr), 32'(v.rd));
      chk($sformatf("v%0d_stall_ready", i), 32'(cmd_ready), 32'd0);
      chk($sformatf("v%0d_stall_busy", i), 32'(busy), 32'd1);
    end
    wb_ready = 1'b1;
    cycle();
    wb_ready = 1'b0;
    chk($sformatf("v%0d_ready_after", i), 32'(cmd_ready), 32'd1);
    chk($sformatf("v%0d_wb_dropped", i), 32'(wb_valid), 32'd0);
    chk($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t v;
    int lat;
    logic seen;

    for (int i = 0; i < 32; i++) rf[i] = '0;
    for (int i = 0; i < 8; i++) rob[i] = '0;
    rf[0] = 32'hBAD0BAD0;  // never read: r0 reads as zero without a request
    rf[1] = 32'h00000001;
    rf[2] = 32'hFFFFFFFF;
    rf[3] = 32'h00000010;
    rf[4] = 32'h80000000;
    rf[6] = 32'h00000024;
    rob[5] = 32'h00000011;
    rob[6] = 32'h00000007;

    //          op     a1r   a1d   rs1    dep1   a2r   a2d   a2i   rs2    dep2  imm       we    rd     iq   nack req exp
    tbl[0]  = '{4'd0,  1'b1, 1'b0, 5'd3,  3'd0,  1'b0, 1'b0, 1'b1, 5'd0,  3'd0, 16'hFFFF, 1'b1, 5'd5,  3'd2, 0, 1, 32'h0000000F};
    tbl[1]  = '{4'd0,  1'b0, 1'b1, 5'd0,  3'd6,  1'b0, 1'b0, 1'b1, 5'd0,  3'd0, 16'h0001, 1'b1, 5'd7,  3'd1, 2, 3, 32'h00000008};
    tbl[2]  = '{4'd7,  1'b1, 1'b0, 5'd4,  3'd0,  1'b1, 1'b0, 1'b0, 5'd6,  3'd0, 16'h0000, 1'b1, 5'd9,  3'd3, 0, 2, 32'hF8000000};
    tbl[3]  = '{4'd5,  1'b1, 1'b0, 5'd1,  3'd0,  1'b0, 1'b0, 1'b1, 5'd0,  3'd0, 16'h001F, 1'b1, 5'd10, 3'd4, 0, 1, 32'h80000000};
    tbl[4]  = '{4'd9,  1'b1, 1'b0, 5'd0,  3'd0,  1'b0, 1'b0, 1'b1, 5'd0,  3'd0, 16'h0001, 1'b1, 5'd11, 3'd5, 0, 0, 32'h00000001};
    tbl[5]  = '{4'd8,  1'b1, 1'b0, 5'd2,  3'd0,  1'b0, 1'b0, 1'b0, 5'd0,  3'd0, 16'h0000, 1'b1, 5'd12, 3'd6, 0, 1, 32'h00000001};
    tbl[6]  = '{4'd1,  1'b1, 1'b0, 5'd3,  3'd0,  1'b0, 1'b1, 1'b0, 5'd0,  3'd5, 16'h0000, 1'b1, 5'd13, 3'd7, 0, 2, 32'hFFFFFFFF};
    tbl[7]  = '{4'd10, 1'b0, 1'b1, 5'd0,  3'd5,  1'b0, 1'b0, 1'b1, 5'd0,  3'd0, 16'h0011, 1'b1, 5'd14, 3'd0, 0, 1, 32'h00000001};
    tbl[8]  = '{4'd4,  1'b1, 1'b0, 5'd3,  3'd0,  1'b0, 1'b0, 1'b1, 5'd0,  3'd0, 16'h8000, 1'b1, 5'd15, 3'd1, 0, 1, 32'hFFFF8010};
    tbl[9]  = '{4'd13, 1'b1, 1'b0, 5'd3,  3'd0,  1'b0, 1'b0, 1'b1, 5'd0,  3'd0, 16'h0005, 1'b1, 5'd16, 3'd2, 0, 1, 32'h00000000};
    tbl[10] = '{4'd12, 1'b0, 1'b0, 5'd0,  3'd0,  1'b1, 1'b0, 1'b1, 5'd0,  3'd0, 16'h0007, 1'b1, 5'd17, 3'd3, 0, 0, 32'h00000000};
    tbl[11] = '{4'd6,  1'b1, 1'b0, 5'd4,  3'd0,  1'b0, 1'b0, 1'b1, 5'd0,  3'd0, 16'h001F, 1'b1, 5'd18, 3'd4, 0, 1, 32'h00000001};
    tbl[12] = '{4'd2,  1'b1, 1'b1, 5'd3,  3'd6,  1'b0, 1'b0, 1'b1, 5'd0,  3'd0, 16'h000F, 1'b1, 5'd19, 3'd5, 0, 1, 32'h00000007};
    tbl[13] = '{4'd11, 1'b1, 1'b0, 5'd3,  3'd0,  1'b1, 1'b0, 1'b0, 5'd4,  3'd0, 16'h0000, 1'b0, 5'd20, 3'd6, 0, 2, 32'h00000001};

    nrst = 1'b0;
    flush = 1'b0;
    cmd_valid = 1'b0;
    wb_ready = 1'b0;
    rd_ack = 1'b0;
    rd_data_valid = 1'b0;
    rd_data = '0;
    drive_cmd(tbl[0]);

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rd_req", 32'(rd_req), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    nrst = 1'b1;
    #1 chk("rel_ready_low", 32'(cmd_ready), 32'd0);
    cycle();
    chk("rel_ready_high", 32'(cmd_ready), 32'd1);

    // Main table.
    for (int i = 0; i < NVec; i++) run_vec(i, 0);

    // Writeback backpressure for three cycles.
    run_vec(0, 3);

    // flush in IDLE only blocks acceptance.
    drive_cmd(tbl[0]);
    cmd_valid = 1'b1;
    flush = 1'b1;
    cycle();
    cmd_valid = 1'b0;
    flush = 1'b0;
    chk("idle_flush_busy", 32'(busy), 32'd0);
    chk("idle_flush_ready", 32'(cmd_ready), 32'd1);

    // flush while operand 2 retries forever.
    v = tbl[10];
    v.a2r = 1'b0;
    v.a2d = 1'b1;
    v.dep2 = 3'd5;
    drive_cmd(v);
    cmd_valid = 1'b1;
    nack_left = 1000;
    cycle();
    cmd_valid = 1'b0;
    cycle();
    cycle();
    chk("rd2_stall_req", 32'(rd_req), 32'd1);
    chk("rd2_stall_dep", 32'(rd_is_dep), 32'd1);
    chk("rd2_stall_addr", 32'(rd_addr), 32'd5);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    nack_left = 0;
    chk("flush_rd_req", 32'(rd_req), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_ready", 32'(cmd_ready), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      seen = seen | wb_valid;
      cycle();
    end
    chk("flush_no_wb", 32'(seen), 32'd0);

    // flush together with wb_ready in WB.
    issue_to_wb(tbl[3], lat);
    chk("fwb_valid", 32'(wb_valid), 32'd1);
    flush = 1'b1;
    wb_ready = 1'b1;
    cycle();
    flush = 1'b0;
    wb_ready = 1'b0;
    chk("fwb_dropped", 32'(wb_valid), 32'd0);
    chk("fwb_idle", 32'(busy), 32'd0);
    chk("fwb_ready", 32'(cmd_ready), 32'd1);

    // Asynchronous reset pulse during WB.
    issue_to_wb(tbl[0], lat);
    chk("arst_pre_valid", 32'(wb_valid), 32'd1);
    #1 nrst = 1'b0;
    #1;
    chk("arst_wb_valid", 32'(wb_valid), 32'd0);
    chk("arst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_wb_data", wb_data, 32'd0);
    nrst = 1'b1;
    #1 chk("arst_rel_ready", 32'(cmd_ready), 32'd0);
    cycle();
    chk("arst_edge_ready", 32'(cmd_ready), 32'd1);
    chk("arst_edge_valid", 32'(wb_valid), 32'd0);

    // Unit recovers for a fresh command.
    run_vec(6, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
